// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline stage: valid/ready register with a one-entry skid buffer behind it.
// Optional STALL_TIMEOUT_EN macro adds a back-pressure watchdog pulse on stall_timeout.
`timescale 1ns/1ps

module id_ex_skid_stage #(
    parameter int CTRL_W    = 11,
    parameter int DATA_W    = 143,
    parameter int MAX_STALL = 3,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              stall_timeout
);

    if (MAX_STALL < 1 || MAX_STALL >= (1 << CNT_W)) begin : g_bad_params
        $error("id_ex_skid_stage: MAX_STALL must be >= 1 and fit in CNT_W bits");
    end

    logic              main_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              main_free;

    // in_ready depends only on registered state, breaking the out_ready->in_ready path.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            out_ctrl   <= '0;
            out_data   <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            out_ctrl   <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                out_ctrl   <= skid_ctrl;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                out_ctrl   <= in_ctrl;
                out_data   <= in_data;
            end else begin
                main_valid <= 1'b0;
                out_ctrl   <= '0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
        end
    end

    // NOTE: skid payload has no reset; it is only ever read while skid_valid is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end

`ifdef STALL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(MAX_STALL - 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             stall_pulse;
    logic             stalled;

    assign stalled = main_valid && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            stall_pulse <= 1'b0;
        end else if (flush || !stalled) begin
            stall_cnt   <= '0;
            stall_pulse <= 1'b0;
        end else if (stall_cnt == STALL_LAST) begin
            stall_cnt   <= '0;
            stall_pulse <= 1'b1;
        end else begin
            stall_cnt   <= stall_cnt + 1'b1;
            stall_pulse <= 1'b0;
        end
    end

    assign stall_timeout = stall_pulse;
`else
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed bench for id_ex_skid_stage: driver pushes accepted beats to a scoreboard queue,
// an independent negedge monitor pops and compares every consumed output beat.
`timescale 1ns/1ps

module tb_id_ex_skid_stage;

    localparam int CTRL_W = 11;
    localparam int DATA_W = 143;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              stall_timeout;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_pops   = 0;
    int    pops_mark;
    bit    mon_en   = 1'b0;

    always #5 clk = ~clk;

    id_ex_skid_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ctrl       (in_ctrl),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ctrl      (out_ctrl),
        .out_data      (out_data),
        .stall_timeout (stall_timeout)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_data(input logic [7:0] k);
        return {k, 127'h0, k};
    endfunction

    function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [7:0] k);
        return {3'b101, k};
    endfunction

    // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic r, input logic f);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
        if (v && in_ready && !f) exp_q.push_back('{ctrl: c, data: d});
        @(posedge clk);
        #1;
        if (f) exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", out_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_pops++;
                    check("beat_ctrl", out_ctrl, mon_e.ctrl);
                    check("beat_data", out_data, mon_e.data);
                end
            end else if (!out_valid) begin
                check("bubble_ctrl", out_ctrl, '0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit exp_to;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ctrl", out_ctrl, '0);
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_timeout", stall_timeout, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset mid-stream with main and skid both occupied
        step(1'b1, mk_ctrl(8'h11), mk_data(8'h11), 1'b0, 1'b0);
        step(1'b1, mk_ctrl(8'h12), mk_data(8'h12), 1'b0, 1'b0);
        check("full_in_ready", in_ready, 1'b0);
        check("full_out_data", out_data, mk_data(8'h11));
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_ctrl", out_ctrl, '0);
        check("midrst_out_data", out_data, '0);
        check("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("postrst_out_valid", out_valid, 1'b0);

        // Streaming: 1-cycle latency, in_ready never drops
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, mk_ctrl(8'(k)), mk_data(8'(k)), 1'b1, 1'b0);
            check("stream_in_ready", in_ready, 1'b1);
            check("stream_out_valid", out_valid, 1'b1);
            check("stream_out_data", out_data, mk_data(8'(k)));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("stream_end_valid", out_valid, 1'b0);
        check("stream_drained", 160'(exp_q.size()), '0);

        // Back-pressure: A on output, B in skid, C held upstream
        pops_mark = n_pops;
        step(1'b1, mk_ctrl(8'hA1), mk_data(8'hA1), 1'b0, 1'b0);
        step(1'b1, mk_ctrl(8'hB2), mk_data(8'hB2), 1'b0, 1'b0);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_data_a", out_data, mk_data(8'hA1));
        step(1'b1, mk_ctrl(8'hC3), mk_data(8'hC3), 1'b0, 1'b0);
        check("bp_hold_ready", in_ready, 1'b0);
        check("bp_hold_data", out_data, mk_data(8'hA1));
        step(1'b1, mk_ctrl(8'hC3), mk_data(8'hC3), 1'b1, 1'b0);
        check("bp_out_data_b", out_data, mk_data(8'hB2));
        check("bp_ready_again", in_ready, 1'b1);
        step(1'b1, mk_ctrl(8'hC3), mk_data(8'hC3), 1'b1, 1'b0);
        check("bp_out_data_c", out_data, mk_data(8'hC3));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("bp_end_valid", out_valid, 1'b0);
        check("bp_beats", 160'(n_pops - pops_mark), 160'd3);

        // Flush with main and skid full; C offered during flush
        step(1'b1, mk_ctrl(8'h41), mk_data(8'h41), 1'b0, 1'b0);
        step(1'b1, mk_ctrl(8'h42), mk_data(8'h42), 1'b0, 1'b0);
        step(1'b1, mk_ctrl(8'h43), mk_data(8'h43), 1'b0, 1'b1);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_out_ctrl", out_ctrl, '0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_data_held", out_data, mk_data(8'h41));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("flush_no_c", out_valid, 1'b0);

        // Flush discards a beat that in_ready would otherwise accept
        step(1'b1, mk_ctrl(8'h44), mk_data(8'h44), 1'b0, 1'b0);
        step(1'b1, mk_ctrl(8'h45), mk_data(8'h45), 1'b0, 1'b1);
        check("flush_wins_valid", out_valid, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("flush_wins_empty", out_valid, 1'b0);

        // Consume in the flush cycle still delivers the beat
        pops_mark = n_pops;
        step(1'b1, mk_ctrl(8'h46), mk_data(8'h46), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        check("flush_consume_beat", 160'(n_pops - pops_mark), 160'd1);
        check("flush_consume_valid", out_valid, 1'b0);

        // Bubble after an all-ones control beat
        step(1'b1, 11'h7FF, mk_data(8'h09), 1'b1, 1'b0);
        check("bubble_pre_ctrl", out_ctrl, 11'h7FF);
        step(1'b0, 11'h7FF, mk_data(8'h09), 1'b1, 1'b0);
        check("bubble_valid", out_valid, 1'b0);
        check("bubble_out_ctrl", out_ctrl, '0);
        check("bubble_data_held", out_data, mk_data(8'h09));

        // Stall watchdog: 7 stalled cycles
        step(1'b1, mk_ctrl(8'hE7), mk_data(8'hE7), 1'b0, 1'b0);
        for (int j = 1; j <= 7; j++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0);
`ifdef STALL_TIMEOUT_EN
            exp_to = (j == 3 || j == 6);
`else
            exp_to = 1'b0;
`endif
            check("stall_timeout", stall_timeout, exp_to);
            check("stall_entry_kept", out_data, mk_data(8'hE7));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("stall_release_valid", out_valid, 1'b0);
        check("stall_release_to", stall_timeout, 1'b0);

        check("final_drain", 160'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
